// File: rtl/da_fir_seq.sv
// da_fir_seq: sequencer for a bit-serial distributed-arithmetic FIR engine.
// It takes one sample at a time from a valid/ready source and launches the engine.
// It waits for the engine to finish and queues each result in a small output FIFO.
// A watchdog covers the engine's busy handshake, and a counter tracks completed samples.
module da_fir_seq #(
    parameter int unsigned OPSIZE     = 12,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned BUSY_WAIT  = 2,
    parameter int unsigned TIMEOUT    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [OPSIZE-1:0] s_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [OPSIZE-1:0] m_data,
    output logic              eng_start,
    output logic [OPSIZE-1:0] eng_xin,
    input  logic              eng_ready,
    input  logic [OPSIZE-1:0] eng_yout,
    output logic              busy,
    output logic              err,
    input  logic              err_clr,
    output logic [15:0]       sample_cnt
);

    localparam int unsigned AW   = $clog2(FIFO_DEPTH);
    localparam int unsigned TMAX = (BUSY_WAIT > TIMEOUT) ? BUSY_WAIT : TIMEOUT;
    localparam int unsigned TW   = $clog2(TMAX + 1);

    localparam logic [TW-1:0] BUSY_LAST = TW'(BUSY_WAIT - 1);
    localparam logic [TW-1:0] DONE_LAST = TW'(TIMEOUT - 1);
    localparam logic [AW:0]   FULL_CNT  = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [OPSIZE-1:0] xin_q, xin_d;
    logic              err_q, err_d;
    logic [15:0]       cnt_q, cnt_d;

    logic [OPSIZE-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]     wr_q, wr_d;
    logic [AW-1:0]     rd_q, rd_d;
    logic [AW:0]       count_q, count_d;

    logic accept;
    logic push;
    logic pop;
    logic start;

    // s_ready is forced low during reset so every output shows its reset value while rst is held.
    assign s_ready = !rst && en && (state_q == IDLE) && eng_ready && (count_q < FULL_CNT);
    assign accept  = s_valid && s_ready;
    assign m_valid = (count_q != '0);
    assign pop     = m_valid && m_ready;

    assign m_data     = m_valid ? mem_q[rd_q] : '0;
    assign eng_start  = start;
    assign eng_xin    = xin_q;
    assign busy       = (state_q != IDLE);
    assign err        = err_q;
    assign sample_cnt = cnt_q;

    // Next-state logic, watchdog timers, result push and error/counter updates.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        xin_d   = xin_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        push    = 1'b0;
        start   = 1'b0;

        // A new watchdog error assigned below overrides this clear.
        if (err_clr) begin
            err_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    xin_d   = s_data;
                    state_d = LAUNCH;
                end
            end
            LAUNCH: begin
                start   = 1'b1;
                timer_d = '0;
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                // The engine must show busy (ready low) before a ready high counts as done.
                if (!eng_ready) begin
                    timer_d = '0;
                    state_d = WAIT_DONE;
                end else if (timer_q == BUSY_LAST) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            WAIT_DONE: begin
                if (eng_ready) begin
                    push    = 1'b1;
                    cnt_d   = cnt_q + 16'd1;
                    state_d = IDLE;
                end else if (timer_q == DONE_LAST) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            timer_q <= '0;
            xin_q   <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            xin_q   <= xin_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    // FIFO pointer and occupancy update. A push and a pop in the same cycle leave the count unchanged.
    always_comb begin
        wr_d    = wr_q;
        rd_d    = rd_q;
        count_d = count_q;
        if (push) begin
            wr_d = wr_q + AW'(1);
        end
        if (pop) begin
            rd_d = rd_q + AW'(1);
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO pointer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end

    // FIFO storage, not reset. m_data is masked to zero while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem_q[wr_q] <= eng_yout;
        end
    end

endmodule
